// File: rtl/step_sequencer.sv
// step_sequencer: tempo-driven pattern step sequencer with a ready/valid note output; define GEN_RANDOM_EN for LFSR probability gating
module step_sequencer #(
   parameter int STEP_DIV  = 3000000,
   parameter int NUM_STEPS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        pat_we,
   input  logic [3:0]  pat_addr,
   input  logic [11:0] pat_wdata,
   output logic [3:0]  step_idx,
   output logic [6:0]  note,
   output logic        note_valid,
   input  logic        note_ready,
   output logic        overflow,
   input  logic        overflow_clr
);
   localparam int CW = $clog2(STEP_DIV);
   localparam int AW = $clog2(NUM_STEPS);
   logic [CW-1:0] cnt;
   logic [11:0]   pat [NUM_STEPS];
   logic [11:0]   entry;
   logic [AW-1:0] rd_a, wr_a, nxt_a;
   logic          step_tick, pass, ev, xfer;
   assign rd_a      = step_idx[AW-1:0];
   assign wr_a      = pat_addr[AW-1:0];
   assign nxt_a     = rd_a + AW'(1);
   assign entry     = pat[rd_a];
   assign step_tick = run && cnt == CW'(STEP_DIV - 1);
   assign xfer      = note_valid && note_ready;
   assign ev        = step_tick && pass;
   // tempo counter, parked at zero while stopped so the first tick lands STEP_DIV cycles after run rises
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt <= '0;
      else cnt <= (!run || step_tick) ? '0 : cnt + CW'(1);
   // pattern store; the step read above sees the entry as it was before a same-cycle write
   always_ff @(posedge clk or posedge reset)
      if (reset) for (int i = 0; i < NUM_STEPS; i++) pat[i] <= '0;
      else if (pat_we) pat[wr_a] <= pat_wdata;
   // step pointer advances on every tick, gated or not
   always_ff @(posedge clk or posedge reset)
      if (reset) step_idx <= '0;
      else if (step_tick) step_idx <= 4'(nxt_a);
`ifdef GEN_RANDOM_EN
   logic [15:0] lfsr;
   // Fibonacci LFSR (taps 16,14,13,11) stepped once per tick; gating uses its pre-advance value
   always_ff @(posedge clk or posedge reset)
      if (reset) lfsr <= 16'hACE1;
      else if (step_tick) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   assign pass = entry[7] && lfsr[3:0] <= entry[11:8];
`else
   logic unused_prob;
   assign unused_prob = ^entry[11:8];
   assign pass = entry[7];
`endif
   // note slot: a new event is taken only when the slot is empty or being emptied, otherwise it is dropped and flagged
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         note       <= '0;
         note_valid <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (ev && (!note_valid || xfer)) begin
            note       <= entry[6:0];
            note_valid <= 1'b1;
         end else if (xfer) note_valid <= 1'b0;
         overflow <= (ev && note_valid && !xfer) || (overflow && !overflow_clr);
      end
endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEP_DIV, default 3000000, clk cycles per step (12 MHz / 4 steps/s); legal >= 2.
REQ-002 SHALL have parameter NUM_STEPS, default 16, pattern length (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level; 1 = sequencer advances.
REQ-006 SHALL have port pat_we  input  1  pattern write strobe.
REQ-007 SHALL have port pat_addr  input  4  step address written, $clog2(NUM_STEPS) LSBs used.
REQ-008 SHALL have port pat_wdata  input  12  step entry {prob[11:8], gate[7], note[6:0]}.
REQ-009 SHALL have port step_idx  output  4  index of next step to play.
REQ-010 SHALL have port note  output  7  note number, stable while note_valid=1.
REQ-011 SHALL have port note_valid  output  1  note available to downstream.
REQ-012 SHALL have port note_ready  input  1  downstream accepts note.
REQ-013 SHALL have port overflow  output  1  sticky: a note event was dropped.
REQ-014 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-015 Tempo counter SHALL count 0..STEP_DIV-1 while run=1, pulse step_tick for one cycle at STEP_DIV-1, wrap to 0.
REQ-016 run=0 SHALL hold tempo counter at 0 and freeze step_idx; first tick after run rises occurs STEP_DIV cycles later.
REQ-017 On step_tick, entry at step_idx SHALL be evaluated and step_idx SHALL increment, wrapping NUM_STEPS-1 -> 0.
REQ-018 Pattern store SHALL be a NUM_STEPS x 12 register array; pat_we writes pat_wdata at pat_addr in one cycle.
REQ-019 Write and step evaluation to same address in same cycle SHALL evaluate the old entry; new entry is visible next cycle.
REQ-020 Evaluated step with gate pass SHALL load note register and set note_valid on the following edge (latency 1 cycle from tick).
REQ-021 Handshake: transfer when note_valid & note_ready; note_valid SHALL clear next cycle unless a new event loads the same cycle.
REQ-022 Transfer and new event in same cycle SHALL load the new note with note_valid remaining 1.
REQ-023 New event while note_valid=1 and no transfer SHALL be dropped, old note retained, overflow set to 1.
REQ-024 overflow_clr SHALL clear overflow; simultaneous set and clear SHALL leave overflow = 1.
REQ-025 run falling SHALL not cancel a pending note; note_valid stays until accepted.
REQ-026 Gate-off steps SHALL advance step_idx without affecting note, note_valid or overflow.

Reset
REQ-027 reset=1 SHALL asynchronously force: tempo counter 0, step_idx 0, note 0, note_valid 0, overflow 0, all pattern entries 0, LFSR 16'hACE1.
REQ-028 Reset mid-step or mid-handshake SHALL discard the pending note; operation restarts from step 0 after release.

Configuration
REQ-029 Macro GEN_RANDOM_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per step_tick; gate passes when gate=1 and lfsr[3:0] <= prob (prob=15 always passes), compared against LFSR value before advancing.
REQ-030 GEN_RANDOM_EN undefined: no LFSR SHALL be instantiated, prob field ignored, gate passes when gate=1.

Verification (STEP_DIV=4, NUM_STEPS=16, note_ready=1 unless stated)
REQ-031 Reset, write step0={F,1,60}, run=1 -> step_tick at cycle 4, note=60 with note_valid=1 at cycle 5, step_idx=1.
REQ-032 Steps 0..15 gate=1 notes 0..15, note_ready=1 for 17 ticks -> notes 0..15 then 0; step_idx wraps 15 -> 0.
REQ-033 note_ready=0, two gated ticks -> note holds first value, overflow=1 after second tick; overflow_clr pulse -> overflow=0.
REQ-034 pat_we to address 2 on the cycle step 2 is evaluated -> old entry played; new entry played on next lap.
REQ-035 reset asserted while note_valid=1 -> note_valid=0, step_idx=0 immediately, before next clk edge.
REQ-036 GEN_RANDOM_EN, all steps gate=1 prob=0, 64 ticks -> notes emitted only on ticks where lfsr[3:0]=0, matching a reference LFSR model; prob=15 -> all 64 emitted.
